// File: rtl/axis_burst_arbiter.sv
// Round-robin arbiter sharing one AXI4-Stream channel among NUM_PORTS sources.
// Each grant carries one fixed-length burst of cfg_data+1 beats, framed by m_axis_tlast.
module axis_burst_arbiter #(
  parameter int AXIS_TDATA_WIDTH = 128,
  parameter int NUM_PORTS        = 4,
  parameter int CNTR_WIDTH       = 16,
  localparam int PORT_WIDTH      = $clog2(NUM_PORTS)
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  input  logic [CNTR_WIDTH-1:0]                 cfg_data,
  input  logic [NUM_PORTS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]                  s_axis_tvalid,
  output logic [NUM_PORTS-1:0]                  s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]           m_axis_tdata,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic                                  m_axis_tlast,
  output logic [PORT_WIDTH-1:0]                 sts_grant
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [PORT_WIDTH-1:0]   grant_q, grant_d;
  logic [PORT_WIDTH-1:0]   last_q, last_d;
  logic [CNTR_WIDTH-1:0]   len_q, len_d;
  logic [CNTR_WIDTH-1:0]   cntr_q, cntr_d;

  logic [PORT_WIDTH-1:0]   winner_s;
  logic [PORT_WIDTH-1:0]   cand_s;
  logic                    found_s;
  logic [AXIS_TDATA_WIDTH-1:0] slice_s [NUM_PORTS];

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_slice
    assign slice_s[k] = s_axis_tdata[k*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
  end

  assign sts_grant = grant_q;

  // Round-robin search starting just after the previous winner, wrapping at NUM_PORTS.
  always_comb begin
    winner_s = last_q;
    cand_s   = last_q;
    found_s  = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand_s = PORT_WIDTH'((int'(last_q) + i) % NUM_PORTS);
      if (!found_s && s_axis_tvalid[cand_s]) begin
        winner_s = cand_s;
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Next-state and output decode; the granted data path is purely combinational.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    len_d         = len_q;
    cntr_d        = cntr_q;
    s_axis_tready = {NUM_PORTS{1'b0}};
    m_axis_tdata  = {AXIS_TDATA_WIDTH{1'b0}};
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          grant_d = winner_s;
          len_d   = cfg_data;
          cntr_d  = {CNTR_WIDTH{1'b0}};
          state_d = ST_BURST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        m_axis_tdata           = slice_s[grant_q];
        m_axis_tvalid          = s_axis_tvalid[grant_q];
        s_axis_tready[grant_q] = m_axis_tready;
        m_axis_tlast           = (cntr_q == len_q);
        if (m_axis_tvalid && m_axis_tready) begin
          if (m_axis_tlast) begin
            // Comparing against len_q rather than incrementing keeps a max-length burst from wrapping.
            cntr_d  = {CNTR_WIDTH{1'b0}};
            last_d  = grant_q;
            state_d = ST_IDLE;
          end else begin
            cntr_d  = cntr_q + CNTR_WIDTH'(1);
          end
        end else begin
          cntr_d = cntr_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      grant_q <= {PORT_WIDTH{1'b0}};
      last_q  <= PORT_WIDTH'(NUM_PORTS - 1);
      len_q   <= {CNTR_WIDTH{1'b0}};
      cntr_q  <= {CNTR_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      len_q   <= len_d;
      cntr_q  <= cntr_d;
    end
  end

endmodule

// File: doc/axis_burst_arbiter.md
Name: axis_burst_arbiter

Overview:
- Round-robin arbiter that shares one AXI4-Stream channel among NUM_PORTS requesters, for example in front of a shared width converter or DMA writer.
- Each grant carries one fixed-length burst of cfg_data+1 beats. The arbiter then re-arbitrates.
- It frames bursts with m_axis_tlast and reports the current owner on sts_grant.

Parameters:
- AXIS_TDATA_WIDTH, 128, width of each slave tdata and of m_axis_tdata.
- NUM_PORTS, 4, number of slave ports; legal range 2..16.
- CNTR_WIDTH, 16, width of the burst beat counter and of cfg_data.

Ports:
- aclk  input  1  clock; all logic on the rising edge.
- aresetn  input  1  synchronous, active-low reset.
- cfg_data  input  CNTR_WIDTH  burst length minus one (0 = single-beat bursts).
- s_axis_tdata  input  NUM_PORTS*AXIS_TDATA_WIDTH  packed slave data; port k occupies slice [k*W +: W].
- s_axis_tvalid  input  NUM_PORTS  per-port valid.
- s_axis_tready  output  NUM_PORTS  per-port ready.
- m_axis_tdata  output  AXIS_TDATA_WIDTH  granted port's data.
- m_axis_tvalid  output  1  granted port's valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tlast  output  1  high on the final beat of each burst.
- sts_grant  output  PORT_WIDTH  index of the granted or most recently granted port. PORT_WIDTH = clog2(NUM_PORTS).

Behaviour:
- Registered state:
  - state: IDLE or BURST.
  - grant_reg: PORT_WIDTH bits.
  - last_reg: PORT_WIDTH bits, previous winner.
  - len_reg: CNTR_WIDTH bits, latched burst length.
  - cntr_reg: CNTR_WIDTH bits, beat counter.
- Reset (aresetn low at a clock edge):
  - state=IDLE, cntr_reg=0, len_reg=0, grant_reg=0.
  - last_reg=NUM_PORTS-1, so port 0 has first priority.
  - All outputs are 0 while in IDLE after reset: s_axis_tready, m_axis_tvalid, m_axis_tlast, sts_grant.
  - Reset mid-burst drops the burst immediately; no tlast is issued for it.
- IDLE:
  - All s_axis_tready=0 and m_axis_tvalid=0.
  - If any s_axis_tvalid is high, the winner is the first asserted port scanning (last_reg+1) mod N upward with wrap.
  - At the next edge: grant_reg=winner, len_reg=cfg_data, cntr_reg=0, state=BURST.
  - If no port is valid, stay in IDLE.
  - This produces exactly one bubble cycle between consecutive bursts.
- BURST (combinational path, zero-cycle latency):
  - m_axis_tdata = slice[grant_reg].
  - m_axis_tvalid = s_axis_tvalid[grant_reg].
  - s_axis_tready[grant_reg] = m_axis_tready; all other readies are 0.
  - m_axis_tlast = (cntr_reg == len_reg).
  - No registered stage on the data path. m_axis_tvalid never depends on m_axis_tready.
- Handshake (BURST, m_axis_tvalid & m_axis_tready):
  - If not the last beat: cntr_reg increments.
  - On the last beat: cntr_reg=0, last_reg=grant_reg, state=IDLE.
- Stalls:
  - If the granted source deasserts tvalid mid-burst, the grant is held and the counter frozen. There is no timeout and no preemption.
  - Downstream backpressure freezes the counter; data and tlast are held stable.
- cfg_data is sampled only on the IDLE→BURST transition. Changes during a burst affect the next burst only.
- sts_grant = grant_reg at all times.
- Fairness: with all ports continuously valid, grants go 0,1,...,N-1,0,... Each port gets one burst per round.
- A port that is not valid is skipped without penalty. A sole requester is re-granted after each bubble.
- Counter arithmetic is CNTR_WIDTH unsigned. cfg_data = 2^CNTR_WIDTH-1 is a legal maximal burst; the counter never wraps before tlast.

Test Plan:
- Only port 2 valid continuously, cfg_data=3, m_axis_tready=1 → bursts of 4 beats with tlast on beat 4 and one idle cycle between bursts. sts_grant=2 and s_axis_tready[2] pulses 4 cycles of every 5.
- All 4 ports valid, cfg_data=1 → grant order 0,1,2,3,0,1. Each burst is 2 beats with data from the correct slice, and non-granted readies stay 0.
- Granted port 1, cfg_data=7; m_axis_tready toggles 1/0 every cycle → 8 handshakes over 15 cycles. tdata and tlast stay stable while ready is low.
- Port 0 drops tvalid for 5 cycles after beat 2 while port 3 is valid → grant remains 0 and cntr_reg is frozen. Burst completes with 4 total beats at cfg_data=3, then port 3 is granted.
- cfg_data changed from 3 to 0 during a burst → current burst is still 4 beats; next burst is 1 beat with tlast on its only beat.
- aresetn pulsed low at beat 2 of a burst → outputs go to 0 the following cycle and no tlast is issued. After release, port 0 wins first when ports 0 and 1 are both valid.
